gf2_solve_sequencer: RTL

//  Per-machine controller for the GF(2) solver path. Accepts one problem (rows/cols)
//  and sequences gf2_rref, then enumerate_solutions. Consumes the solution stream and

---
 rtl/axi_stream_if.sv | 12 +
 rtl/gf2_solve_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream beat interface (data, valid/ready, last).
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gf2_solve_sequencer.sv
// Sequences rref then enumeration per machine, keeps min-weight solution and a running total.
// 1 cycle from prob/rref_done/final beat to the next pulse or res_valid; result held until res_ready.
module gf2_solve_sequencer #(
  parameter int  MAX_ROWS       = 16,
  parameter int  MAX_COLS       = 16,
  parameter int  AXI_DATA_WIDTH = 8,
  parameter int  TOTAL_W        = 32,
  localparam int ROWS_W         = $clog2(MAX_ROWS + 1),
  localparam int COLS_W         = $clog2(MAX_COLS + 1),
  localparam int WT_W           = $clog2(MAX_COLS - 1 + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prob_valid,
  output logic               prob_ready,
  input  logic [ROWS_W-1:0]  prob_rows,
  input  logic [COLS_W-1:0]  prob_cols,
  output logic [ROWS_W-1:0]  rows,
  output logic [COLS_W-1:0]  cols,
  output logic               rref_start,
  input  logic               rref_done,
  output logic               enum_start,
  axi_stream_if.slave        solution_stream,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WT_W-1:0]    res_weight,
  output logic               res_err,
  input  logic               clr_total,
  output logic [TOTAL_W-1:0] total,
  output logic               busy
);

  localparam int MAX_NB = (MAX_COLS - 1 + AXI_DATA_WIDTH - 1) / AXI_DATA_WIDTH;
  localparam int BEAT_W = $clog2(MAX_NB + 1);

  typedef enum logic [1:0] {S_IDLE, S_RREF, S_ENUM, S_RESULT} state_t;

  state_t              state_q, state_d;
  logic                first_q;
  logic                armed_q;
  logic [ROWS_W-1:0]   rows_q;
  logic [COLS_W-1:0]   cols_q;
  logic [COLS_W-1:0]   vars_q;
  logic [BEAT_W-1:0]   nb_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [WT_W-1:0]     cur_wt;
  logic [WT_W-1:0]     min_wt;
  logic                err_q;
  logic [TOTAL_W-1:0]  total_q;

  logic                prob_acc;
  logic                beat_acc;
  logic                last_beat;
  logic                res_hs;
  logic [WT_W-1:0]     beat_pop;
  logic [WT_W-1:0]     cand;
  logic [BEAT_W-1:0]   nb_d;

  // Only bits below vars count; positions are absolute across the beats of one solution.
  always_comb begin
    beat_pop = '0;
    for (int j = 0; j < AXI_DATA_WIDTH; j++) begin
      if ((int'(beat_cnt) * AXI_DATA_WIDTH + j) < int'(vars_q) && solution_stream.tdata[j])
        beat_pop = beat_pop + WT_W'(1);
    end
  end

  assign cand      = cur_wt + beat_pop;
  assign last_beat = (beat_cnt == nb_q - BEAT_W'(1));
  assign nb_d      = BEAT_W'((int'(prob_cols) + AXI_DATA_WIDTH - 2) / AXI_DATA_WIDTH);
  assign prob_acc  = prob_valid && prob_ready;
  assign beat_acc  = (state_q == S_ENUM) && solution_stream.tvalid;
  assign res_hs    = (state_q == S_RESULT) && res_ready;
  assign solution_stream.tready = (state_q == S_ENUM);

  always_comb begin
    state_d    = state_q;
    prob_ready = 1'b0;
    rref_start = 1'b0;
    enum_start = 1'b0;
    res_valid  = 1'b0;
    res_weight = '0;
    res_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        prob_ready = armed_q;
        if (prob_valid && armed_q)
          state_d = (prob_cols < COLS_W'(2)) ? S_RESULT : S_RREF;
      end
      S_RREF: begin
        rref_start = first_q;
        if (rref_done) state_d = S_ENUM;
      end
      S_ENUM: begin
        enum_start = first_q;
        if (beat_acc && solution_stream.tlast) state_d = S_RESULT;
      end
      S_RESULT: begin
        res_valid  = 1'b1;
        res_weight = min_wt;
        res_err    = err_q;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
    end
  end

  // armed_q keeps prob_ready low while reset is asserted and for the first cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q  <= 1'b0;
      rows_q   <= '0;
      cols_q   <= '0;
      vars_q   <= '0;
      nb_q     <= '0;
      beat_cnt <= '0;
      cur_wt   <= '0;
      min_wt   <= '0;
      err_q    <= 1'b0;
      total_q  <= '0;
    end else begin
      armed_q <= 1'b1;
      if (prob_acc) begin
        rows_q <= prob_rows;
        cols_q <= prob_cols;
        vars_q <= prob_cols - COLS_W'(1);
        nb_q   <= nb_d;
        min_wt <= '0;
        err_q  <= 1'b0;
      end
      if (state_q == S_RREF && rref_done) begin
        cur_wt   <= '0;
        beat_cnt <= '0;
        err_q    <= 1'b0;
        min_wt   <= '1;
      end
      if (beat_acc) begin
        if (last_beat) begin
          if (cand < min_wt) min_wt <= cand;
          cur_wt   <= '0;
          beat_cnt <= '0;
        end else if (solution_stream.tlast) begin
          err_q    <= 1'b1;
          cur_wt   <= '0;
          beat_cnt <= '0;
        end else begin
          cur_wt   <= cand;
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
      if (clr_total)
        total_q <= '0;
      else if (res_hs)
        total_q <= total_q + TOTAL_W'(min_wt);
    end
  end

  assign rows  = rows_q;
  assign cols  = cols_q;
  assign total = total_q;
  assign busy  = (state_q != S_IDLE);

endmodule
